// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES fetch front end.
package aes_pkg;

  localparam int BLK_W = 128;
  localparam int ROW_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  // Row 0 lands in the most significant word of the block.
  function automatic logic [BLK_W-1:0] pack_rows(
    input logic [ROW_W-1:0] r0,
    input logic [ROW_W-1:0] r1,
    input logic [ROW_W-1:0] r2,
    input logic [ROW_W-1:0] r3
  );
    return {r0, r1, r2, r3};
  endfunction

endpackage

// File: rtl/block_fifo.sv
// Small block FIFO: synchronous push/pop, occupancy count, head read from
// registered storage so it is stable while not popped.
module block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [BLK_W-1:0]         wdata,
  input  logic                     pop,
  output logic [BLK_W-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [BLK_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);

  // Storage, pointers and occupancy; reset clears contents so the head reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/aes_block_fetch.sv
// Fetches 128-bit blocks from the row memory into a FIFO and hands them to
// the round core. Handshake: a block transfers on any posedge where
// blk_valid && blk_ready; blk_valid never depends on blk_ready and
// blk_data holds steady while blk_valid is high and no transfer occurs.
module aes_block_fetch
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mem_empty,
  input  logic [ROW_W-1:0]   mem_row0,
  input  logic [ROW_W-1:0]   mem_row1,
  input  logic [ROW_W-1:0]   mem_row2,
  input  logic [ROW_W-1:0]   mem_row3,
  output logic               mem_ren,
  output logic               blk_valid,
  output logic [BLK_W-1:0]   blk_data,
  input  logic               blk_ready,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   block_count,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  fetch_state_e  state;
  logic [CW-1:0] count;
  logic          pop;

  // A full FIFO blocks the read even when a pop happens the same cycle.
  assign mem_ren   = (state == FETCH) && !mem_empty && (count != FULL_CNT);
  assign blk_valid = (count != '0);
  assign pop       = blk_valid && blk_ready;

  block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (mem_ren),
    .wdata (pack_rows(mem_row0, mem_row1, mem_row2, mem_row3)),
    .pop   (pop),
    .head  (blk_data),
    .count (count)
  );

  // Run control and delivered-block counter; start is only honoured in IDLE/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      block_count <= '0;
    end else begin
      if (pop) begin
        block_count <= block_count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            block_count <= '0;
          end
        end
        FETCH: begin
          if (mem_empty) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((count == '0) || ((count == ONE_CNT) && pop)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (start) begin
            state       <= FETCH;
            block_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == FETCH) || (state == DRAIN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_aes_block_fetch.sv
// Bench for aes_block_fetch: a row memory model, a queue of expected blocks
// derived from the memory image, and one task per scenario.
module tb_aes_block_fetch;
  import aes_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mem_empty;
  logic [31:0]      mem_row0, mem_row1, mem_row2, mem_row3;
  logic             mem_ren;
  logic             blk_valid;
  logic [127:0]     blk_data;
  logic             blk_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] block_count;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model
  logic [127:0] mem_arr [0:31];
  int           pc = 0;
  logic         rewind = 1'b0;
  logic [127:0] stage[$];
  logic [127:0] exp_q[$];

  // per-run observations
  int ren_cnt, ren_hold, ren_first, ren_last, done_cyc, delivered;
  bit valid_seen;

  aes_block_fetch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_empty   (mem_empty),
    .mem_row0    (mem_row0),
    .mem_row1    (mem_row1),
    .mem_row2    (mem_row2),
    .mem_row3    (mem_row3),
    .mem_ren     (mem_ren),
    .blk_valid   (blk_valid),
    .blk_data    (blk_data),
    .blk_ready   (blk_ready),
    .busy        (busy),
    .done        (done),
    .block_count (block_count),
    .state_dbg   (state_dbg)
  );

  // clock / memory pc
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rewind) pc <= 0;
    else if (mem_ren) pc <= pc + 1;
  end

  assign mem_row0  = mem_arr[pc & 31][127:96];
  assign mem_row1  = mem_arr[pc & 31][95:64];
  assign mem_row2  = mem_arr[pc & 31][63:32];
  assign mem_row3  = mem_arr[pc & 31][31:0];
  assign mem_empty = (mem_arr[pc & 31] == 128'h0);

  // Load the staged image; the expected stream is everything before the first zero block.
  task automatic load_mem();
    bit stop = 0;
    for (int i = 0; i < 32; i++) mem_arr[i] = '0;
    exp_q.delete();
    foreach (stage[i]) begin
      mem_arr[i] = stage[i];
      if (stage[i] == 128'h0) stop = 1;
      if (!stop) exp_q.push_back(stage[i]);
    end
    @(negedge clk); rewind = 1'b1;
    @(negedge clk); rewind = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  // mode 0: always ready; 1: not ready for `hold` cycles then ready; 2: random ready
  task automatic run_stream(input string name, input int mode, input int hold, input int budget);
    int cyc = 0;
    bit fin = 0;
    bit pv = 0;
    logic [127:0] prev = '0;
    logic [127:0] first_blk;
    logic [127:0] exp;
    int exp_n;
    exp_n = exp_q.size();
    first_blk = (exp_n > 0) ? exp_q[0] : '0;
    ren_cnt = 0; ren_hold = 0; ren_first = -1; ren_last = -1;
    done_cyc = -1; delivered = 0; valid_seen = 0;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      if (mode == 0) blk_ready = 1'b1;
      else if (cyc < hold) blk_ready = 1'b0;
      else if (mode == 1) blk_ready = 1'b1;
      else blk_ready = 1'($urandom_range(0, 1));
      #1;
      if (mem_ren) begin
        ren_cnt++;
        if (cyc < hold) ren_hold++;
        if (ren_first < 0) ren_first = cyc;
        ren_last = cyc;
      end
      if (blk_valid) valid_seen = 1;
      if (mode == 1 && cyc < hold && blk_valid) begin
        n_checks++;
        if (blk_data !== first_blk) begin
          n_fail++;
          $display("FAIL %s head_held cyc=%0d: got %h expected %h", name, cyc, blk_data, first_blk);
        end
      end
      if (pv) begin
        n_checks++;
        if (blk_data !== prev) begin
          n_fail++;
          $display("FAIL %s head_stable cyc=%0d: got %h expected %h", name, cyc, blk_data, prev);
        end
      end
      if (blk_valid && blk_ready) begin
        delivered++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_block: got %h expected none", name, blk_data);
        end else begin
          exp = exp_q.pop_front();
          if (blk_data !== exp) begin
            n_fail++;
            $display("FAIL %s block_data #%0d: got %h expected %h", name, delivered, blk_data, exp);
          end
        end
        pv = 0;
      end else begin
        pv = blk_valid;
        prev = blk_data;
      end
      if (done) begin
        fin = 1;
        done_cyc = cyc;
      end
      cyc++;
    end
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s done_timeout: got no done after %0d cycles, expected done", name, budget);
    end
    n_checks++;
    if (block_count !== CNT_W'(exp_n)) begin
      n_fail++;
      $display("FAIL %s block_count: got %0d expected %0d", name, block_count, exp_n);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_blocks: got %0d undelivered expected 0", name, exp_q.size());
    end
    n_checks++;
    if (busy !== 1'b0 || blk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_outputs: got busy=%b valid=%b expected 0 0", name, busy, blk_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; blk_ready = 1'b0;
    stage.delete();
    load_mem();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({mem_ren, blk_valid, busy, done} !== 4'b0000 || blk_data !== '0 ||
        block_count !== '0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_values: got ren=%b valid=%b busy=%b done=%b data=%h cnt=%0d st=%0d expected all 0",
               mem_ren, blk_valid, busy, done, blk_data, block_count, state_dbg);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    stage = '{128'h00112233_44556677_8899aabb_ccddeeff,
              128'h01010101_02020202_03030303_04040404,
              128'hdeadbeef_cafef00d_12345678_9abcdef0,
              128'h0};
    load_mem();
    pulse_start();
    run_stream("basic", 0, 0, 50);
    n_checks++;
    if (ren_cnt != 3 || (ren_last - ren_first + 1) != 3) begin
      n_fail++;
      $display("FAIL basic ren_pattern: got %0d strobes over %0d cycles expected 3 over 3",
               ren_cnt, ren_last - ren_first + 1);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic done: got %b expected 1", done);
    end
  endtask

  task automatic test_restart();
    n_checks++;
    if (done !== 1'b1 || block_count !== CNT_W'(3)) begin
      n_fail++;
      $display("FAIL restart_pre: got done=%b cnt=%0d expected 1 3", done, block_count);
    end
    stage = '{128'hfeedface_0badc0de_11223344_55667788, 128'h0};
    load_mem();
    pulse_start();
    n_checks++;
    if (block_count !== '0 || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: got cnt=%0d done=%b busy=%b expected 0 0 1", block_count, done, busy);
    end
    run_stream("restart", 0, 0, 50);
  endtask

  task automatic test_backpressure();
    stage = '{128'h00112233_44556677_8899aabb_ccddeeff,
              128'h01010101_02020202_03030303_04040404,
              128'hdeadbeef_cafef00d_12345678_9abcdef0,
              128'h0};
    load_mem();
    pulse_start();
    run_stream("backpressure", 1, 10, 60);
    n_checks++;
    if (ren_hold != 2 || ren_cnt != 3) begin
      n_fail++;
      $display("FAIL backpressure ren: got hold=%0d total=%0d expected 2 3", ren_hold, ren_cnt);
    end
  endtask

  task automatic test_empty_stream();
    stage = '{128'h0, 128'h11111111_11111111_11111111_11111111};
    load_mem();
    pulse_start();
    run_stream("empty", 0, 0, 20);
    n_checks++;
    if (ren_cnt != 0 || valid_seen || done_cyc < 0 || done_cyc > 2) begin
      n_fail++;
      $display("FAIL empty_path: got ren=%0d valid_seen=%0d done_cyc=%0d expected 0 0 <=2",
               ren_cnt, valid_seen, done_cyc);
    end
  endtask

  task automatic test_zero_word();
    stage = '{128'h11111111_00000000_33333333_44444444, 128'h0};
    load_mem();
    pulse_start();
    run_stream("zero_word", 0, 0, 30);
    n_checks++;
    if (ren_cnt != 1 || delivered != 1) begin
      n_fail++;
      $display("FAIL zero_word counts: got ren=%0d delivered=%0d expected 1 1", ren_cnt, delivered);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int nblk;
      int mode;
      nblk = $urandom_range(0, 6);
      mode = (it % 2 == 0) ? 2 : 1;
      stage.delete();
      for (int b = 0; b < nblk; b++) begin
        logic [31:0] r [4];
        for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
        if (r[0] == 0 && r[1] == 0 && r[2] == 0 && r[3] == 0) r[3] = 32'h1;
        stage.push_back({r[0], r[1], r[2], r[3]});
      end
      stage.push_back(128'h0);
      load_mem();
      pulse_start();
      run_stream("random", mode, $urandom_range(0, 6), 300);
      n_checks++;
      if (ren_cnt != nblk) begin
        n_fail++;
        $display("FAIL random reads it=%0d: got %0d expected %0d", it, ren_cnt, nblk);
      end
    end
  endtask

  task automatic test_reset_mid();
    stage = '{128'ha0a0a0a0_a1a1a1a1_a2a2a2a2_a3a3a3a3,
              128'hb0b0b0b0_b1b1b1b1_b2b2b2b2_b3b3b3b3,
              128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3,
              128'hd0d0d0d0_d1d1d1d1_d2d2d2d2_d3d3d3d3,
              128'h0};
    load_mem();
    pulse_start();
    blk_ready = 1'b1;                 // cycle 1: push block a
    @(posedge clk); #1;               // cycle 2: pop a, push b
    @(posedge clk); #1;               // cycle 3: push c, fifo fills
    blk_ready = 1'b0;
    @(posedge clk); #1;               // cycle 4: full, holding b and c
    n_checks++;
    if (blk_valid !== 1'b1 || mem_ren !== 1'b0 || block_count !== CNT_W'(1) ||
        state_dbg !== FETCH || blk_data !== stage[1]) begin
      n_fail++;
      $display("FAIL reset_mid full: got valid=%b ren=%b cnt=%0d st=%0d data=%h expected 1 0 1 1 %h",
               blk_valid, mem_ren, block_count, state_dbg, blk_data, stage[1]);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (block_count !== CNT_W'(1) || busy !== 1'b1 || state_dbg !== FETCH) begin
      n_fail++;
      $display("FAIL reset_mid start_ignored: got cnt=%0d busy=%b st=%0d expected 1 1 1",
               block_count, busy, state_dbg);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (blk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_ren !== 1'b0 ||
        block_count !== '0 || state_dbg !== IDLE || blk_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid after: got valid=%b busy=%b done=%b ren=%b cnt=%0d st=%0d data=%h expected all 0",
               blk_valid, busy, done, mem_ren, block_count, state_dbg, blk_data);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_backpressure();
    test_empty_stream();
    test_zero_word();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
